// File: rtl/ex_wb_stage.sv
// ex_wb_stage: EX->WB pipeline register and writeback stage.
// Registers the EX result, selects writeback data (zero / LUI / ALU / GPIO switches),
// owns the HEX GPIO output register and forwards WB data back into EX.
// Optional feature: define GPIO_SYNC_EN to route gpio_in through a SYNC_STAGES-deep
// synchronizer; otherwise gpio_in feeds the writeback mux directly.
module ex_wb_stage #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_EX,
    input  logic            regwrite_EX,
    input  logic [1:0]      regsel_EX,
    input  logic            GPIO_we,
    input  logic [4:0]      rd_EX,
    input  logic [4:0]      rs1_EX,
    input  logic [4:0]      rs2_EX,
    input  logic [XLEN-1:0] rs1_data_EX,
    input  logic [XLEN-1:0] rs2_data_EX,
    input  logic [XLEN-1:0] alu_result_EX,
    input  logic [19:0]     imm20_EX,
    input  logic [XLEN-1:0] gpio_in,
    output logic [XLEN-1:0] rs1_fwd_EX,
    output logic [XLEN-1:0] rs2_fwd_EX,
    output logic            regwrite_WB,
    output logic [4:0]      rd_WB,
    output logic [XLEN-1:0] writedata_WB,
    output logic [XLEN-1:0] gpio_out
);

    // A single flop cannot be trusted to resolve metastability on the switch inputs.
    if (SYNC_STAGES < 2) begin : g_sync_stages_check
        $error("ex_wb_stage: SYNC_STAGES must be at least 2");
    end

    logic [XLEN-1:0] gpio_s;
    logic [XLEN-1:0] wb_data_d;
    logic            wb_we_d;

`ifdef GPIO_SYNC_EN
    logic [SYNC_STAGES-1:0][XLEN-1:0] sync_q;

    // Shift the asynchronous switch inputs through the synchronizer chain
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in};
        end
    end

    assign gpio_s = sync_q[SYNC_STAGES-1];
`else
    // Direct path: only valid when gpio_in is driven synchronously to clk.
    assign gpio_s = gpio_in;
`endif

    // Forward the WB result into EX; x0 never matches because regwrite_WB is 0 for rd=0
    always_comb begin
        rs1_fwd_EX = rs1_data_EX;
        rs2_fwd_EX = rs2_data_EX;
        if (regwrite_WB && (rd_WB == rs1_EX)) begin
            rs1_fwd_EX = writedata_WB;
        end
        if (regwrite_WB && (rd_WB == rs2_EX)) begin
            rs2_fwd_EX = writedata_WB;
        end
    end

    // Writeback data select and write-enable qualification
    always_comb begin
        wb_data_d = '0;
        unique case (regsel_EX)
            2'b00: wb_data_d = '0;
            2'b01: wb_data_d = XLEN'({imm20_EX, 12'h000});
            2'b10: wb_data_d = alu_result_EX;
            2'b11: wb_data_d = gpio_s;
        endcase
        wb_we_d = regwrite_EX && !flush_EX && (rd_EX != 5'd0);
    end

    // EX->WB pipeline register; reset drops any in-flight write
    always_ff @(posedge clk) begin
        if (rst) begin
            regwrite_WB  <= 1'b0;
            rd_WB        <= 5'd0;
            writedata_WB <= '0;
        end else begin
            regwrite_WB  <= wb_we_d;
            rd_WB        <= rd_EX;
            writedata_WB <= wb_data_d;
        end
    end

    // HEX display register, written with the forwarded rs1 operand unless squashed
    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_out <= '0;
        end else if (GPIO_we && !flush_EX) begin
            gpio_out <= rs1_fwd_EX;
        end
    end

endmodule
